mem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the picorv32 native memory interface. It shares the single on-chip byte-lane memory between two requesters (CPU core 0 and core 1 or a DMA engine) with round-robin fairness. The grant is held for the whole transaction, and a watchdog completes any transaction the slave never acknowledges. It sits between the masters' mem_* buses and the memory controller's mem_* port.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave arbiter for the picorv32 native memory bus.
// Round-robin between master 0 and master 1. The grant is held for the whole
// transaction. A watchdog completes transactions that the slave never acknowledges.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   m0_* / m1_*                     master request buses (valid/instr/wstrb/wdata/addr in,
//                                   ready/rdata out)
//   s_valid, s_instr, s_wstrb,
//   s_wdata, s_addr                 forwarded request to the memory controller
//   s_ready, s_rdata                memory acknowledge and read data
//   grant                           one-hot current owner, 00 when idle
//   timeout_err                     one-cycle pulse when the watchdog completes a transaction
//
// The bus handshake outputs (s_*, m*_ready, m*_rdata) are combinational from the
// state register and the owner's inputs. The picorv32 protocol needs ready in the
// same cycle as the slave acknowledge. timeout_err and grant decode the state
// register only.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // The counter never needs more than TIMEOUT+1 codes. Keep at least one bit so
  // that TIMEOUT=0 (watchdog disabled) still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;    // master served most recently (1 = master 1)
  logic             owner_q, owner_d;  // owner remembered for the ERR cycle
  logic [CNT_W-1:0] cnt_q, cnt_d;      // slave-wait cycles in the current BUSY

  logic busy1;
  logic own_valid;
  logic wd_expire;

  // Watchdog fires on the last allowed wait cycle when it is enabled.
  assign wd_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and bus steering
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    busy1       = 1'b0;
    own_valid   = 1'b0;
    grant       = 2'b00;
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_wstrb     = 4'b0000;
    s_wdata     = 32'h0;
    s_addr      = 32'h0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // When both masters request, the master that was not served last wins.
        if (m0_valid && (!m1_valid || last_q)) begin
          state_d = BUSY0;
          owner_d = 1'b0;
        end else if (m1_valid) begin
          state_d = BUSY1;
          owner_d = 1'b1;
        end
      end

      BUSY0, BUSY1: begin
        busy1     = (state_q == BUSY1);
        own_valid = busy1 ? m1_valid : m0_valid;
        grant     = busy1 ? 2'b10 : 2'b01;
        s_valid   = own_valid;
        s_instr   = busy1 ? m1_instr : m0_instr;
        s_wstrb   = busy1 ? m1_wstrb : m0_wstrb;
        s_wdata   = busy1 ? m1_wdata : m0_wdata;
        s_addr    = busy1 ? m1_addr  : m0_addr;
        if (busy1) begin
          m1_rdata = s_rdata;
        end else begin
          m0_rdata = s_rdata;
        end

        if (!own_valid) begin
          // The master withdrew its request. Drop the transaction without a ready.
          state_d = IDLE;
          last_d  = busy1;
        end else if (s_ready) begin
          // An acknowledge wins over a watchdog expiring in the same cycle.
          m0_ready = !busy1;
          m1_ready = busy1;
          state_d  = IDLE;
          last_d   = busy1;
        end else if (wd_expire) begin
          state_d = ERR;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ERR: begin
        // Complete toward the owner with the error pattern. The slave sees nothing.
        grant       = owner_q ? 2'b10 : 2'b01;
        timeout_err = 1'b1;
        if (owner_q) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
        cnt_d   = '0;
        state_d = IDLE;
        last_d  = owner_q;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A transaction-level model of the arbitration rules
// predicts every output on every cycle. Directed scenarios add literal
// expectations on grant order, latency, read data and the error pulse.
module tb_mem_arbiter;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] ERR_D = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          abort_after;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid, m0_instr, m1_instr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_wdata, m1_wdata, m0_addr, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready, s_instr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_addr, s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR_D)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_instr(s_instr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request queues, slave latency control and memory contents
  req_t q0[$];
  req_t q1[$];
  int   slave_lat = 1;  // s_ready on the (lat+1)-th s_valid cycle; 0 = never
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] ws, input int ab);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = ws; r.instr = a[2]; r.abort_after = ab;
    return r;
  endfunction

  // Observation logs filled by the monitor
  logic [1:0]  gs_val[$];
  int          gs_cyc[$];
  int          dn_m[$];
  logic [31:0] dn_d[$];
  int          dn_cyc[$];
  int          terr_cnt = 0;
  int          rise_cyc = 0;

  task automatic clear_logs();
    gs_val.delete(); gs_cyc.delete(); dn_m.delete(); dn_d.delete(); dn_cyc.delete();
    terr_cnt = 0;
  endtask

  // Master driver: holds each request until ready, then loads the next one
  req_t cur [2];
  int   held [2];
  initial begin
    logic r0, r1, v, rd;
    m0_valid = 0; m0_instr = 0; m0_wstrb = 0; m0_wdata = 0; m0_addr = 0;
    m1_valid = 0; m1_instr = 0; m1_wstrb = 0; m1_wdata = 0; m1_addr = 0;
    held[0] = 0; held[1] = 0;
    forever begin
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        v  = (m == 0) ? m0_valid : m1_valid;
        rd = (m == 0) ? r0 : r1;
        if (v) begin
          held[m]++;
          if (rd || (cur[m].abort_after != 0 && held[m] >= cur[m].abort_after)) begin
            v = 1'b0;
            if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
          end
        end
        if (!v && ((m == 0) ? q0.size() : q1.size()) > 0) begin
          cur[m]  = (m == 0) ? q0.pop_front() : q1.pop_front();
          held[m] = 0;
          if (m == 0) begin
            m0_valid = 1; m0_addr = cur[m].addr; m0_wdata = cur[m].wdata;
            m0_wstrb = cur[m].wstrb; m0_instr = cur[m].instr;
          end else begin
            m1_valid = 1; m1_addr = cur[m].addr; m1_wdata = cur[m].wdata;
            m1_wstrb = cur[m].wstrb; m1_instr = cur[m].instr;
          end
        end
      end
    end
  end

  // Memory slave with a registered, programmable-latency ready
  initial begin
    logic sv, sr;
    logic [31:0] a, wd, nw;
    logic [3:0]  ws;
    int vcnt;
    s_ready = 0; s_rdata = 0; vcnt = 0;
    forever begin
      @(negedge clk);
      sv = s_valid; sr = s_ready; a = s_addr; ws = s_wstrb; wd = s_wdata;
      @(posedge clk); #1;
      if (!resetn) begin
        s_ready = 0; vcnt = 0;
      end else begin
        if (sv && sr && ws != 4'b0000) begin
          nw = mem_rd(a);
          for (int b = 0; b < 4; b++) if (ws[b]) nw[8*b +: 8] = wd[8*b +: 8];
          mem[a] = nw;
        end
        if (!sv || sr) begin
          s_ready = 0; vcnt = 0;
        end else begin
          vcnt++;
          s_ready = (slave_lat != 0) && (vcnt == slave_lat);
        end
      end
      s_rdata = s_ready ? mem_rd(a) : 32'hDEAD_BEEF;
    end
  end

  // Transaction model and per-cycle compare
  int   cyc = 0;
  int   ph = 0;        // 0 idle, 1 serving, 2 error completion
  int   own = 0;
  int   mlast = 1;
  int   busy_cyc = 0;
  logic prev_v0 = 0;
  logic [1:0] prev_grant = 0;
  initial begin
    logic [1:0] e_grant;
    logic e_sv, e_si, e_r0, e_r1, e_te, ov;
    logic [3:0] e_sw;
    logic [31:0] e_sd, e_sa, e_d0, e_d1;
    forever begin
      @(negedge clk);
      cyc++;
      e_grant = 0; e_sv = 0; e_si = 0; e_sw = 0; e_sd = 0; e_sa = 0;
      e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; e_te = 0; ov = 0;
      if (resetn === 1'b1) begin
        if (ph == 1) begin
          ov      = (own == 0) ? m0_valid : m1_valid;
          e_grant = (own == 0) ? 2'b01 : 2'b10;
          e_sv    = ov;
          e_si    = (own == 0) ? m0_instr : m1_instr;
          e_sw    = (own == 0) ? m0_wstrb : m1_wstrb;
          e_sd    = (own == 0) ? m0_wdata : m1_wdata;
          e_sa    = (own == 0) ? m0_addr  : m1_addr;
          if (own == 0) begin e_d0 = s_rdata; e_r0 = ov & s_ready; end
          else          begin e_d1 = s_rdata; e_r1 = ov & s_ready; end
        end else if (ph == 2) begin
          e_grant = (own == 0) ? 2'b01 : 2'b10;
          e_te    = 1;
          if (own == 0) begin e_r0 = 1; e_d0 = ERR_D; end
          else          begin e_r1 = 1; e_d1 = ERR_D; end
        end
      end
      chk("grant",       32'(grant),       32'(e_grant));
      chk("s_valid",     32'(s_valid),     32'(e_sv));
      chk("s_instr",     32'(s_instr),     32'(e_si));
      chk("s_wstrb",     32'(s_wstrb),     32'(e_sw));
      chk("s_wdata",     s_wdata,          e_sd);
      chk("s_addr",      s_addr,           e_sa);
      chk("m0_ready",    32'(m0_ready),    32'(e_r0));
      chk("m1_ready",    32'(m1_ready),    32'(e_r1));
      chk("m0_rdata",    m0_rdata,         e_d0);
      chk("m1_rdata",    m1_rdata,         e_d1);
      chk("timeout_err", 32'(timeout_err), 32'(e_te));

      if (m0_ready) begin dn_m.push_back(0); dn_d.push_back(m0_rdata); dn_cyc.push_back(cyc); end
      if (m1_ready) begin dn_m.push_back(1); dn_d.push_back(m1_rdata); dn_cyc.push_back(cyc); end
      if (grant != 2'b00 && prev_grant == 2'b00) begin gs_val.push_back(grant); gs_cyc.push_back(cyc); end
      if (timeout_err) terr_cnt++;
      if (m0_valid && !prev_v0) rise_cyc = cyc;
      prev_grant = grant;
      prev_v0    = m0_valid;

      // What the next clock edge does to the transaction
      if (resetn !== 1'b1) begin
        ph = 0; mlast = 1;
      end else begin
        case (ph)
          0: if (m0_valid || m1_valid) begin
               own = (m0_valid && m1_valid) ? 1 - mlast : (m0_valid ? 0 : 1);
               ph = 1; busy_cyc = 1;
             end
          1: if (!ov || s_ready) begin ph = 0; mlast = own; end
             else if (TO != 0 && busy_cyc == TO) ph = 2;
             else busy_cyc++;
          default: begin ph = 0; mlast = own; end
        endcase
      end
    end
  end

  task automatic wait_quiet(input int budget, input string tag);
    int q = 0;
    int n = 0;
    while (q < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (q0.size() == 0 && q1.size() == 0 && !m0_valid && !m1_valid && grant == 2'b00) q++;
      else q = 0;
    end
    checks++;
    if (q < 3) begin
      failures++;
      $display("FAIL %s_wait: bus still busy after %0d cycles, required idle", tag, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3 resetn = 0;
    repeat (2) @(posedge clk);
    #2 resetn = 1;
  endtask

  initial begin
    int bad;
    int n;
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    mem[32'h100] = 32'h1234_5678;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",   32'(grant),       32'h0);
    chk("rst_s_valid", 32'(s_valid),     32'h0);
    chk("rst_ready",   32'({m0_ready, m1_ready}), 32'h0);
    chk("rst_terr",    32'(timeout_err), 32'h0);
    @(posedge clk); #2 resetn = 1;

    // Single read
    slave_lat = 1;
    clear_logs();
    @(negedge clk);
    q0.push_back(mk(32'h100, 32'h0, 4'h0, 0));
    wait_quiet(50, "t1");
    chk("t1_grant",   32'(gs_val[0]), 32'h1);
    chk("t1_lat",     32'(gs_cyc[0] - rise_cyc), 32'd1);
    chk("t1_ndone",   32'(dn_m.size()), 32'd1);
    chk("t1_rdata",   dn_d[0], 32'h1234_5678);
    chk("t1_done",    32'(dn_cyc[0] - gs_cyc[0]), 32'd1);

    // Simultaneous requests from reset
    do_reset();
    clear_logs();
    @(negedge clk);
    q0.push_back(mk(32'h0, 32'h0, 4'h0, 0));
    q1.push_back(mk(32'h40, 32'hCAFE_F00D, 4'hF, 0));
    wait_quiet(60, "t2");
    chk("t2_order",   32'({gs_val[0], gs_val[1]}), 32'b0110);
    chk("t2_ndone",   32'(dn_m.size()), 32'd2);
    chk("t2_dorder",  32'({dn_m[0][1:0], dn_m[1][1:0]}), 32'b0001);
    chk("t2_gap",     32'(gs_cyc[1] - dn_cyc[0]), 32'd2);
    chk("t2_rdata0",  dn_d[0], 32'h5A5A_0000);
    chk("t2_write",   mem_rd(32'h40), 32'hCAFE_F00D);

    // Round-robin streaming
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(32'h1000 + 32'(4 * i), 32'h0, 4'h0, 0));
      q1.push_back(mk(32'h2000 + 32'(4 * i), 32'h0, 4'h0, 0));
    end
    wait_quiet(300, "t3");
    chk("t3_ndone", 32'(dn_m.size()), 32'd20);
    bad = 0;
    for (int i = 0; i < gs_val.size(); i++)
      if (gs_val[i] != ((i % 2 == 0) ? 2'b01 : 2'b10)) bad++;
    chk("t3_alternate", 32'(bad), 32'd0);
    chk("t3_rdata0", dn_d[0], 32'h5A5A_1000);
    chk("t3_rdata1", dn_d[1], 32'h5A5A_2000);

    // Watchdog expiry
    slave_lat = 0;
    clear_logs();
    @(negedge clk);
    q1.push_back(mk(32'h200, 32'h0, 4'h0, 0));
    wait_quiet(60, "t4a");
    chk("t4a_terr",  32'(terr_cnt), 32'd1);
    chk("t4a_owner", 32'(dn_m[0]), 32'd1);
    chk("t4a_rdata", dn_d[0], 32'h0000_0000);
    chk("t4a_cycles", 32'(dn_cyc[0] - gs_cyc[0]), 32'd4);

    // Acknowledge on the expiry cycle wins
    slave_lat = 3;
    clear_logs();
    @(negedge clk);
    q1.push_back(mk(32'h204, 32'h0, 4'h0, 0));
    wait_quiet(60, "t4b");
    chk("t4b_terr",  32'(terr_cnt), 32'd0);
    chk("t4b_rdata", dn_d[0], 32'h5A5A_0204);
    chk("t4b_cycles", 32'(dn_cyc[0] - gs_cyc[0]), 32'd3);

    // Reset in the middle of a master-1 transaction
    slave_lat = 0;
    clear_logs();
    @(negedge clk);
    q1.push_back(mk(32'h300, 32'h0, 4'h0, 0));
    n = 0;
    while (grant != 2'b10 && n < 20) begin @(negedge clk); n++; end
    chk("t5_busy1", 32'(grant), 32'h2);
    @(posedge clk); #3 resetn = 0;
    #1;
    chk("t5_s_valid", 32'(s_valid),  32'h0);
    chk("t5_grant",   32'(grant),    32'h0);
    chk("t5_m1_ready", 32'(m1_ready), 32'h0);
    clear_logs();
    @(negedge clk);
    q0.push_back(mk(32'h310, 32'h0, 4'h0, 0));
    slave_lat = 1;
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    wait_quiet(60, "t5");
    chk("t5_order",  32'({gs_val[0], gs_val[1]}), 32'b0110);
    chk("t5_ndone",  32'(dn_m.size()), 32'd2);
    chk("t5_rdata0", dn_d[0], 32'h5A5A_0310);

    // Master 0 withdraws before acknowledge; pending master 1 proceeds
    slave_lat = 3;
    clear_logs();
    @(negedge clk);
    q0.push_back(mk(32'h400, 32'h0, 4'h0, 2));
    q1.push_back(mk(32'h404, 32'h0, 4'h0, 0));
    wait_quiet(60, "t6");
    chk("t6_order", 32'({gs_val[0], gs_val[1]}), 32'b0110);
    chk("t6_ndone", 32'(dn_m.size()), 32'd1);
    chk("t6_owner", 32'(dn_m[0]), 32'd1);
    chk("t6_rdata", dn_d[0], 32'h5A5A_0404);
    chk("t6_terr",  32'(terr_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
